// File: rtl/test_result_dev.sv
// Simulation result device: memory-mapped STATUS/CODE/CYCLE/SCRATCH registers
// that a CPU test program writes to report pass/fail, plus a watchdog timeout.
module test_result_dev #(
    parameter logic [31:0] TIMEOUT = 32'd100000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        test_done,
    output logic        test_pass,
    output logic [31:0] test_code,
    output logic [31:0] cycle_cnt
);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    localparam logic [31:0] TIMEOUT_CODE = 32'hDEAD0001;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] code_q, code_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic        accept;
    logic        wr_acc;
    logic        status_wr;
    logic        timeout_hit;
    logic [1:0]  reg_sel;
    logic [31:0] rd_mux;
    logic        unused_addr;

    assign unused_addr = ^{req_addr[31:4], req_addr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign reg_sel     = req_addr[3:2];
    assign accept      = (state_q == IDLE) && req_valid;
    assign wr_acc      = accept && req_wr;
    assign status_wr   = wr_acc && (reg_sel == 2'd0) && req_wstrb[0] && !done_q;
    assign timeout_hit = (TIMEOUT != 32'd0) && !done_q
                         && (cnt_q == TIMEOUT - 32'd1);

    // Reads always see the register values from before this cycle's update
    always_comb begin
        rd_mux = 32'd0;
        unique case (reg_sel)
            2'd0: rd_mux = {30'd0, pass_q, done_q};
            2'd1: rd_mux = code_q;
            2'd2: rd_mux = cnt_q;
            2'd3: rd_mux = scratch_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        code_d    = code_q;
        scratch_d = scratch_q;
        done_d    = done_q;
        pass_d    = pass_q;
        cnt_d     = cnt_q;

        if (!done_q && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = RESP;
                    rdata_d = req_wr ? 32'd0 : rd_mux;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
        endcase

        if (wr_acc) begin
            unique case (reg_sel)
                2'd0: begin
                    if (status_wr) begin
                        done_d = 1'b1;
                        pass_d = (req_wdata == 32'h1);
                    end
                end
                2'd1: begin
                    if (!done_q) code_d = merge(code_q, req_wdata, req_wstrb);
                end
                2'd2: ;
                2'd3: scratch_d = merge(scratch_q, req_wdata, req_wstrb);
            endcase
        end

        // A result reported by software wins over the watchdog
        if (timeout_hit && !status_wr) begin
            done_d = 1'b1;
            pass_d = 1'b0;
            code_d = TIMEOUT_CODE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rdata_q   <= 32'd0;
            code_q    <= 32'd0;
            scratch_q <= 32'd0;
            cnt_q     <= 32'd0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            code_q    <= code_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign test_done  = done_q;
    assign test_pass  = pass_q;
    assign test_code  = code_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_test_result_dev.sv
// Directed bench for test_result_dev: register access, handshake stall,
// sticky result, watchdog timeout and reset during a pending response.
module tb_test_result_dev;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        test_done;
    logic        test_pass;
    logic [31:0] test_code;
    logic [31:0] cycle_cnt;

    logic        to_resetn;
    logic        to_req_valid;
    logic        to_req_ready;
    logic        to_req_wr;
    logic [31:0] to_req_addr;
    logic [31:0] to_req_wdata;
    logic [3:0]  to_req_wstrb;
    logic        to_resp_valid;
    logic        to_resp_ready;
    logic [31:0] to_resp_rdata;
    logic        to_done;
    logic        to_pass;
    logic [31:0] to_code;
    logic [31:0] to_cnt;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] tb_cyc;
    logic [31:0] frozen;

    localparam logic [31:0] A_STATUS  = 32'h0;
    localparam logic [31:0] A_CODE    = 32'h4;
    localparam logic [31:0] A_CYCLE   = 32'h8;
    localparam logic [31:0] A_SCRATCH = 32'hC;

    always #5 clk = ~clk;

    test_result_dev u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .test_done  (test_done),
        .test_pass  (test_pass),
        .test_code  (test_code),
        .cycle_cnt  (cycle_cnt)
    );

    test_result_dev #(.TIMEOUT(32'd20)) u_to (
        .clk        (clk),
        .resetn     (to_resetn),
        .req_valid  (to_req_valid),
        .req_ready  (to_req_ready),
        .req_wr     (to_req_wr),
        .req_addr   (to_req_addr),
        .req_wdata  (to_req_wdata),
        .req_wstrb  (to_req_wstrb),
        .resp_valid (to_resp_valid),
        .resp_ready (to_resp_ready),
        .resp_rdata (to_resp_rdata),
        .test_done  (to_done),
        .test_pass  (to_pass),
        .test_code  (to_code),
        .cycle_cnt  (to_cnt)
    );

    // Reference cycle counter: clock edges seen since reset release
    always @(posedge clk or negedge resetn) begin
        if (!resetn) tb_cyc <= 32'd0;
        else         tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single access with resp_ready=1; called and returns on a falling edge
    task automatic bus(input string tag, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_rd);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_vld"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_rd"}, resp_rdata, exp_rd);
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        to_resetn     = 1'b0;
        req_valid     = 1'b0;
        req_wr        = 1'b0;
        req_addr      = 32'd0;
        req_wdata     = 32'd0;
        req_wstrb     = 4'd0;
        resp_ready    = 1'b1;
        to_req_valid  = 1'b0;
        to_req_wr     = 1'b0;
        to_req_addr   = 32'd0;
        to_req_wdata  = 32'd0;
        to_req_wstrb  = 4'd0;
        to_resp_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_done", {31'd0, test_done}, 32'd0);
        chk("rst_pass", {31'd0, test_pass}, 32'd0);
        chk("rst_code", test_code, 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);
        chk("to_rst_cnt", to_cnt, 32'd0);

        // Watchdog: fires on the edge where the count is 19
        to_resetn = 1'b1;
        repeat (19) @(negedge clk);
        chk("to_cnt19", to_cnt, 32'd19);
        chk("to_pre_done", {31'd0, to_done}, 32'd0);
        @(negedge clk);
        chk("to_done", {31'd0, to_done}, 32'd1);
        chk("to_pass", {31'd0, to_pass}, 32'd0);
        chk("to_code", to_code, 32'hDEAD0001);
        chk("to_cnt20", to_cnt, 32'd20);
        repeat (5) @(negedge clk);
        chk("to_frozen", to_cnt, 32'd20);

        // Main device
        resetn = 1'b1;
        @(negedge clk);
        chk("cnt1", cycle_cnt, 32'd1);
        chk("cnt_model", cycle_cnt, tb_cyc);
        bus("rd_cycle", 1'b0, A_CYCLE, 32'd0, 4'h0, 32'd1);
        chk("cnt_run", cycle_cnt, tb_cyc);

        bus("wr_scr_all", 1'b1, A_SCRATCH, 32'hFFFF_FFFF, 4'hF, 32'd0);
        bus("wr_scr_b0", 1'b1, A_SCRATCH, 32'h0000_0012, 4'b0001, 32'd0);
        bus("rd_scr", 1'b0, A_SCRATCH, 32'd0, 4'h0, 32'hFFFF_FF12);
        bus("wr_cycle", 1'b1, A_CYCLE, 32'h0, 4'hF, 32'd0);
        chk("cnt_no_wr", cycle_cnt, tb_cyc);
        bus("wr_code_hi", 1'b1, A_CODE + 32'h10, 32'hAB00_0000, 4'b1000, 32'd0);
        bus("rd_code_hi", 1'b0, A_CODE, 32'd0, 4'h0, 32'hAB00_0000);
        bus("wr_st_nostrb", 1'b1, A_STATUS, 32'h1, 4'b1110, 32'd0);
        chk("st_ignored", {31'd0, test_done}, 32'd0);

        // Stalled response with a competing request held high
        req_valid  = 1'b1;
        req_wr     = 1'b0;
        req_addr   = A_SCRATCH;
        resp_ready = 1'b0;
        @(negedge clk);
        req_addr   = A_CODE;
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld", {31'd0, resp_valid}, 32'd1);
            chk("stall_rd", resp_rdata, 32'hFFFF_FF12);
            chk("stall_rdy", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        chk("stall_last", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);
        chk("stall_end", {31'd0, resp_valid}, 32'd0);

        // Failing result is sticky
        bus("wr_code7", 1'b1, A_CODE, 32'h7, 4'hF, 32'd0);
        bus("wr_st6", 1'b1, A_STATUS, 32'h6, 4'hF, 32'd0);
        frozen = tb_cyc - 32'd1;
        chk("f_done", {31'd0, test_done}, 32'd1);
        chk("f_pass", {31'd0, test_pass}, 32'd0);
        chk("f_code", test_code, 32'h7);
        bus("rd_st_f", 1'b0, A_STATUS, 32'd0, 4'h0, 32'h1);
        bus("wr_st1_late", 1'b1, A_STATUS, 32'h1, 4'hF, 32'd0);
        chk("f_pass_sticky", {31'd0, test_pass}, 32'd0);
        bus("wr_code_late", 1'b1, A_CODE, 32'h9, 4'hF, 32'd0);
        chk("f_code_sticky", test_code, 32'h7);
        chk("f_cnt_frozen", cycle_cnt, frozen);

        // Reset while a response is pending
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_wr     = 1'b0;
        req_addr   = A_CODE;
        @(negedge clk);
        req_valid  = 1'b0;
        chk("pre_rst_vld", {31'd0, resp_valid}, 32'd1);
        chk("pre_rst_rd", resp_rdata, 32'h7);
        #2 resetn = 1'b0;
        #1;
        chk("arst_vld", {31'd0, resp_valid}, 32'd0);
        chk("arst_rdy", {31'd0, req_ready}, 32'd1);
        chk("arst_rd", resp_rdata, 32'd0);
        chk("arst_done", {31'd0, test_done}, 32'd0);
        chk("arst_pass", {31'd0, test_pass}, 32'd0);
        chk("arst_code", test_code, 32'd0);
        chk("arst_cnt", cycle_cnt, 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus("rd_scr_rst", 1'b0, A_SCRATCH, 32'd0, 4'h0, 32'd0);

        // Passing result
        bus("wr_st1", 1'b1, A_STATUS, 32'h1, 4'hF, 32'd0);
        bus("rd_st_p", 1'b0, A_STATUS, 32'd0, 4'h0, 32'h3);
        chk("p_done", {31'd0, test_done}, 32'd1);
        chk("p_pass", {31'd0, test_pass}, 32'd1);
        chk("p_code", test_code, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
